// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator: prescaled pixel strobe, h/v position
// counters and registered sync/blank outputs with an optional pix_ce-clocked delay line.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SYNC_DELAY = 0,
  parameter int unsigned CW         = 10
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_ce,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          nblank,
  output logic          vga_blank_z,
  output logic          vga_comp_synch,
  output logic          hsync,
  output logic          vsync,
  output logic          EndLine,
  output logic          EndFrame
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PW     = 3 * (SYNC_DELAY + 1);

  if ((((HTotal - 1) >> CW) != 0) || (((VTotal - 1) >> CW) != 0)) begin : g_cw_check
    $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
  end
  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if ((H_SYNC == 0) || (V_SYNC == 0)) begin : g_sync_check
    $error("vga_timing_gen: sync widths must be non-zero");
  end
  if (SYNC_DELAY > 7) begin : g_dly_check
    $error("vga_timing_gen: SYNC_DELAY must be 0..7");
  end

  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HLast   = CW'(HTotal - 1);
  localparam logic [CW-1:0] VLast   = CW'(VTotal - 1);
  localparam logic [CW-1:0] HActEnd = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActEnd = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HsFirst = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HsLast  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VsFirst = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VsLast  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Delay-line stage layout: {hsync level, vsync level, nblank}.
  localparam logic [2:0] Inactive = {~HS_POL, ~VS_POL, 1'b0};

  logic [DW-1:0] div_q;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic [PW-1:0] pipe_q, pipe_d;
  logic [2:0]    stage_in;
  logic          end_line;

  // Reset gates the strobe so pix_ce/EndLine/EndFrame drop immediately with reset.
  always_comb begin
    pix_ce   = reset & enable & (div_q == DivLast);
    end_line = pix_ce & (h_q == HLast);
    EndLine  = end_line;
    EndFrame = end_line & (v_q == VLast);
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_ce) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Sync/blank for the position being entered, so stage 0 always matches x_pos/y_pos.
  always_comb begin
    stage_in[2] = ((h_d >= HsFirst) && (h_d <= HsLast)) ? HS_POL : ~HS_POL;
    stage_in[1] = ((v_d >= VsFirst) && (v_d <= VsLast)) ? VS_POL : ~VS_POL;
    stage_in[0] = (h_d < HActEnd) && (v_d < VActEnd);
  end

  // Newest stage in the low bits; the output taps the oldest.
  if (SYNC_DELAY == 0) begin : g_no_dly
    assign pipe_d = stage_in;
  end else begin : g_dly
    assign pipe_d = {pipe_q[3*SYNC_DELAY-1:0], stage_in};
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      pipe_q <= {(SYNC_DELAY + 1){Inactive}};
    end else if (enable) begin
      div_q <= (div_q == DivLast) ? '0 : div_q + 1'b1;
      h_q   <= h_d;
      v_q   <= v_d;
      if (pix_ce) begin
        pipe_q <= pipe_d;
      end
    end
  end

  assign x_pos          = h_q;
  assign y_pos          = v_q;
  assign hsync          = pipe_q[3*SYNC_DELAY+2];
  assign vsync          = pipe_q[3*SYNC_DELAY+1];
  assign nblank         = pipe_q[3*SYNC_DELAY];
  assign vga_blank_z    = pipe_q[3*SYNC_DELAY];
  assign vga_comp_synch = 1'b1;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/SVGA raster timing generator, the next generation of the fixed 640x480 controller. Horizontal and vertical geometry, sync polarity, pixel-clock division and a sync/blank pipeline delay are all parameters. A run enable freezes the raster. The block drives x_pos/y_pos to the pixel/tile renderer and hsync/vsync/blank to the DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level (0 = active-low)
CLK_DIV, 2, sys_clk cycles per pixel; must be >= 1
SYNC_DELAY, 0, extra pixel periods of delay on hsync/vsync/nblank/vga_blank_z relative to x_pos/y_pos; range 0..7
CW, 10, counter/position width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  run enable; low freezes the raster
pix_ce  out  1  pixel strobe, one sys_clk wide
x_pos  out  CW  current horizontal count, 0..H_TOTAL-1
y_pos  out  CW  current vertical count, 0..V_TOTAL-1
nblank  out  1  high in the active video region
vga_blank_z  out  1  copy of nblank for the DAC blank pin
vga_comp_synch  out  1  constant 1
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
EndLine  out  1  last pixel of line
EndFrame  out  1  last pixel of frame

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Line order: active, front porch, sync, back porch. Active is h 0..H_ACTIVE-1. Hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Vertical order is identical in lines.
- Prescaler: div counts 0..CLK_DIV-1 while enable=1. pix_ce=1 for exactly the sys_clk cycle in which div==CLK_DIV-1 and enable=1. With CLK_DIV=1, pix_ce=enable.
- Counters advance only on pix_ce. h wraps from H_TOTAL-1 to 0. On that wrap, v increments, wrapping from V_TOTAL-1 to 0.
- x_pos=h and y_pos=v, registered. Porch and sync values are visible; there is no clamping.
- EndLine = pix_ce && h==H_TOTAL-1. EndFrame = EndLine && v==V_TOTAL-1. Each is a single sys_clk pulse coincident with the pix_ce that wraps the counter.
- Sync and blank outputs are registered and glitch-free.
  - SYNC_DELAY=0: in any cycle they describe the current (x_pos, y_pos).
  - SYNC_DELAY=D: they pass through a D-stage shift register clocked by pix_ce, so they describe the position D pixels earlier. This compensates for renderer pipeline latency.
- nblank = h_active && v_active, delayed as above. vga_blank_z is always equal to nblank.
- enable=0: div, counters, delay line and all registered outputs hold their values. pix_ce, EndLine and EndFrame are 0. On the first cycle with enable=1, counting resumes from the held div value.
- Reset (reset=0, any time, including mid-frame), values apply immediately:
  - div=0, x_pos=0, y_pos=0
  - pix_ce=0, EndLine=0, EndFrame=0
  - nblank=0, vga_blank_z=0
  - hsync=~HS_POL, vsync=~VS_POL
  - every delay-line stage loaded with these inactive values
- After reset is released, the first pix_ce arrives CLK_DIV cycles later (given enable=1) and moves x_pos to 1. Until the first pix_ce, the outputs keep their reset values.
- Elaboration error if CW is too small, CLK_DIV<1, any sync width is 0, or SYNC_DELAY>7.

Test Plan:
- Defaults, enable=1, release reset -> pix_ce every 2nd cycle. x_pos steps 0,1,2... After x_pos=799 it returns to 0 and y_pos goes 0->1. EndLine pulses once per 1600 sys_clk.
- Defaults, horizontal sync and blank -> hsync=0 exactly for x_pos 656..751 (192 sys_clk). nblank=0 from x_pos 640 onward. vsync=0 for y_pos 490..491. EndFrame pulses once every 840000 sys_clk, at x_pos=799, y_pos=524.
- HS_POL=1, VS_POL=1, CLK_DIV=1 -> hsync is high for x_pos 656..751, is 0 during reset, and pix_ce is constantly 1.
- SYNC_DELAY=2 -> hsync falls on the pix_ce where x_pos becomes 658. nblank falls when x_pos becomes 642. x_pos timing is identical to SYNC_DELAY=0.
- Drop enable for 10 cycles at x_pos=300 -> all outputs frozen, no pix_ce. Counting resumes with correct spacing after enable returns.
- Assert reset at x_pos=400, y_pos=200 -> x_pos, y_pos and nblank go to 0 and hsync/vsync go inactive in the same cycle, before any clock edge. After release, a full default frame is 840000 cycles.
